// File: rtl/pwm_dac_if.sv
// Signal bundle between a sample source/controller and the PWM DAC.
// The master side drives control and samples; the slave side is the DAC.
interface pwm_dac_if;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clear_flags;
    logic       pwm_out;
    logic       sample_taken;
    logic       overrun;
    logic       underrun;

    modport master (
        output enable,
        output sample_in,
        output sample_valid,
        output clear_flags,
        input  pwm_out,
        input  sample_taken,
        input  overrun,
        input  underrun
    );

    modport slave (
        input  enable,
        input  sample_in,
        input  sample_valid,
        input  clear_flags,
        output pwm_out,
        output sample_taken,
        output overrun,
        output underrun
    );
endinterface

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC with a 256-clock period. Signed samples are buffered in a
// one-entry register and promoted to the active duty (as offset binary) on
// the last count of each period. Sticky flags report lost and missing samples.
module pwm_dac (
    input  logic       clk,
    input  logic       rst_n,
    pwm_dac_if.slave   bus
);

    logic [7:0] cnt_q,      cnt_d;
    logic [7:0] active_q,   active_d;
    logic [7:0] pend_q,     pend_d;
    logic       pendFull_q, pendFull_d;
    logic       pwm_q,      pwm_d;
    logic       taken_q,    taken_d;
    logic       overrun_q,  overrun_d;
    logic       underrun_q, underrun_d;

    logic loadEvent;
    logic loadSample;
    logic overrunSet;
    logic underrunSet;

    // A load event is the final count of a running period; it consumes the
    // buffer if something is waiting, otherwise it flags an underrun. A strobe
    // that lands on a consuming load refills the freed slot and is not an overrun.
    always_comb begin
        loadEvent   = bus.enable && (cnt_q == 8'd255);
        loadSample  = loadEvent && pendFull_q;
        underrunSet = loadEvent && !pendFull_q;
        overrunSet  = bus.sample_valid && pendFull_q && !loadEvent;

        cnt_d      = bus.enable ? cnt_q + 8'd1 : 8'd0;
        active_d   = loadSample ? (pend_q ^ 8'h80) : active_q;
        pend_d     = bus.sample_valid ? bus.sample_in : pend_q;
        pendFull_d = pendFull_q;
        if (loadSample) begin
            pendFull_d = 1'b0;
        end
        if (bus.sample_valid) begin
            pendFull_d = 1'b1;
        end
        taken_d    = loadSample;
        pwm_d      = bus.enable && (cnt_q < active_q);
        overrun_d  = overrunSet  || (overrun_q  && !bus.clear_flags);
        underrun_d = underrunSet || (underrun_q && !bus.clear_flags);
    end

    // State register with synchronous reset; reset starts at mid-scale duty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= 8'd0;
            active_q   <= 8'h80;
            pend_q     <= 8'd0;
            pendFull_q <= 1'b0;
            pwm_q      <= 1'b0;
            taken_q    <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pendFull_q <= pendFull_d;
            pwm_q      <= pwm_d;
            taken_q    <= taken_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.sample_taken = taken_q;
    assign bus.overrun      = overrun_q;
    assign bus.underrun     = underrun_q;

endmodule
